// File: rtl/add_pkg.sv
// Shared definitions for the byte-serial adder: byte width and controller states.
package add_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/add_seq_add.sv
// 8-bit adder with carry in/out; the single byte datapath shared by every byte of add_seq.
module add
  import add_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              ci,
  output logic              co,
  output logic [BYTE_W-1:0] y
);

  assign {co, y} = {1'b0, a} + {1'b0, b} + {{BYTE_W{1'b0}}, ci};

endmodule

// File: rtl/add_seq.sv
// Byte-serial multi-byte adder: operands are fed LSB byte first through one 8-bit adder,
// with the carry registered between bytes; the wide sum is published with a one-cycle done.
module add_seq
  import add_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [BYTE_W*NBYTES-1:0] a,
  input  logic [BYTE_W*NBYTES-1:0] b,
  input  logic                     ci,
  output logic                     busy,
  output logic                     done,
  output logic [BYTE_W*NBYTES-1:0] y,
  output logic                     co
);

  localparam int W  = BYTE_W * NBYTES;
  localparam int CW = $clog2(NBYTES) + 1;

  state_t            r_state;
  state_t            w_state_next;
  logic [W-1:0]      r_a_sh;
  logic [W-1:0]      r_b_sh;
  logic [W-1:0]      r_y_sh;
  logic [W-1:0]      r_y;
  logic              r_co;
  logic              r_carry;
  logic [CW-1:0]     r_cnt;
  logic [BYTE_W-1:0] w_s;
  logic              w_c;
  logic              w_last;
  logic [W-1:0]      w_y_sh_next;

  add u_add (
    .a  (r_a_sh[BYTE_W-1:0]),
    .b  (r_b_sh[BYTE_W-1:0]),
    .ci (r_carry),
    .co (w_c),
    .y  (w_s)
  );

  assign w_last = (r_cnt == CW'(NBYTES - 1));

  // New byte enters at the top so that after NBYTES shifts byte 0 sits at the bottom.
  generate
    if (NBYTES == 1) begin : g_one_byte
      assign w_y_sh_next = w_s;
    end else begin : g_multi_byte
      assign w_y_sh_next = {w_s, r_y_sh[W-1:BYTE_W]};
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = RUN;
      RUN:     if (w_last) w_state_next = DONE;
      DONE:    w_state_next = start ? RUN : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_y_sh  <= '0;
      r_y     <= '0;
      r_co    <= 1'b0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_carry <= ci;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_a_sh  <= r_a_sh >> BYTE_W;
          r_b_sh  <= r_b_sh >> BYTE_W;
          r_y_sh  <= w_y_sh_next;
          r_carry <= w_c;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            r_y  <= w_y_sh_next;
            r_co <= w_c;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);
  assign y    = r_y;
  assign co   = r_co;

endmodule

// File: tb/tb_add_seq.sv
// Directed bench for add_seq: a wide-arithmetic reference model checked every cycle,
// plus hand-computed literal results, latencies and reset behaviour.
module tb_add_seq;

  localparam int NBYTES = 4;
  localparam int W      = 8 * NBYTES;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         ci = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] y;
  logic         co;

  int n_vec = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  add_seq #(.NBYTES(NBYTES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .ci    (ci),
    .busy  (busy),
    .done  (done),
    .y     (y),
    .co    (co)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: result is plain wide addition, available NBYTES edges after acceptance.
  int           m_remain = 0;
  logic [W:0]   m_pend   = '0;
  logic [W-1:0] m_y      = '0;
  logic         m_co     = 1'b0;
  logic         m_done   = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_remain = 0;
      m_pend   = '0;
      m_y      = '0;
      m_co     = 1'b0;
      m_done   = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_remain > 0) begin
        m_remain = m_remain - 1;
        if (m_remain == 0) begin
          m_y    = m_pend[W-1:0];
          m_co   = m_pend[W];
          m_done = 1'b1;
        end
      end else if (start) begin
        m_pend   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
        m_remain = NBYTES;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_busy", 64'(busy), 64'(m_remain > 0));
      chk("model_done", 64'(done), 64'(m_done));
      chk("model_y",    64'(y),    64'(m_y));
      chk("model_co",   64'(co),   64'(m_co));
    end
  end

  // Pulses start for one cycle (optionally re-pulses it mid-RUN) and checks the literal result.
  task automatic do_op(input string nm, input logic [W-1:0] pa, input logic [W-1:0] pb,
                       input logic pci, input bit mid, input logic [W-1:0] ey, input logic eco);
    int lat;
    int bc;
    bit seen;
    @(negedge clk);
    a = pa; b = pb; ci = pci; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1; bc = 0; seen = 1'b0;
    while (lat <= 20 && !seen) begin
      if (busy) bc++;
      if (done) begin
        seen = 1'b1;
      end else begin
        if (mid && lat == 2) begin
          start = 1'b1; a = '1; b = '1; ci = 1'b1;
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
        lat++;
      end
    end
    chk({nm, "_latency"}, 64'(lat), 64'd5);
    chk({nm, "_busy_cycles"}, 64'(bc), 64'd4);
    chk({nm, "_y"}, 64'(y), 64'(ey));
    chk({nm, "_co"}, 64'(co), 64'(eco));
    $display("op %s: a=%h b=%h ci=%0d -> y=%h co=%0d latency=%0d", nm, pa, pb, pci, y, co, lat);
    @(negedge clk);
    chk({nm, "_single_done"}, 64'(done), 64'd0);
  endtask

  initial begin
    int lat;
    int nd;
    #3 rst_n = 1'b0;
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_y", 64'(y), 64'd0);
    chk("reset_co", 64'(co), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op("fe_plus_1",   32'h000000FE, 32'h00000001, 1'b0, 1'b0, 32'h000000FF, 1'b0);
    do_op("byte_carry",  32'h000000FE, 32'h00000001, 1'b1, 1'b0, 32'h00000100, 1'b0);
    do_op("full_ripple", 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1);
    do_op("msb_carry",   32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1);
    do_op("mid_start",   32'h12345678, 32'h11111111, 1'b0, 1'b1, 32'h23456789, 1'b0);

    // Back-to-back: second start presented during the DONE cycle.
    @(negedge clk);
    a = 32'h0000FFFF; b = 32'h00000001; ci = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (lat <= 20 && !done) begin
      @(negedge clk);
      lat++;
    end
    chk("b2b_first_latency", 64'(lat), 64'd5);
    chk("b2b_first_y", 64'(y), 64'h00010000);
    a = 32'hAABBCCDD; b = 32'h11223344; ci = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy_rerise", 64'(busy), 64'd1);
    chk("b2b_done_dropped", 64'(done), 64'd0);
    chk("b2b_y_held", 64'(y), 64'h00010000);
    lat = 1;
    while (lat <= 20 && !done) begin
      chk("b2b_y_stable", 64'(y), 64'h00010000);
      @(negedge clk);
      lat++;
    end
    chk("b2b_second_latency", 64'(lat), 64'd5);
    chk("b2b_second_y", 64'(y), 64'hBBDE0022);
    chk("b2b_second_co", 64'(co), 64'd0);
    $display("op b2b: second y=%h co=%0d latency=%0d", y, co, lat);

    // Asynchronous reset two edges into RUN.
    @(negedge clk);
    a = 32'h01010101; b = 32'h02020202; ci = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_busy", 64'(busy), 64'd0);
    chk("async_done", 64'(done), 64'd0);
    chk("async_y", 64'(y), 64'd0);
    chk("async_co", 64'(co), 64'd0);
    $display("op async_reset: busy=%0d done=%0d y=%h co=%0d", busy, done, y, co);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("no_done_after_reset", 64'(nd), 64'd0);
    do_op("after_reset", 32'h01010101, 32'h02020202, 1'b0, 1'b0, 32'h03030303, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
